// File: rtl/sd_cmd_tx_if.sv
// sd_cmd_tx_if: command-line bus; master drives shift_enable/load/cmd_index/cmd_arg, slave returns ready/cmd_out/cmd_oe/done
interface sd_cmd_tx_if;
  logic        shift_enable;
  logic        load;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ready;
  logic        cmd_out;
  logic        cmd_oe;
  logic        done;
  modport master (output shift_enable, load, cmd_index, cmd_arg, input ready, cmd_out, cmd_oe, done);
  modport slave (input shift_enable, load, cmd_index, cmd_arg, output ready, cmd_out, cmd_oe, done);
endinterface

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serializes 48-bit SD command frames (start, dir, index, arg, CRC7, end) onto CMD; ports clk, rst, bus (slave)
module sd_cmd_tx #(
  parameter int NUM_IDLE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  sd_cmd_tx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state, state_d;
  logic [5:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic [6:0]  crc, crc_d;
  logic [47:0] frame;
  logic        cur_bit, tick_send, tick_gap;
  logic        out_q, oe_q, done_q, out_d, oe_d, done_d;
  assign frame     = {2'b01, idx, arg, crc, 1'b1};
  assign cur_bit   = frame[bit_cnt];
  assign crc_d     = {crc[5:0], 1'b0} ^ ({7{cur_bit ^ crc[6]}} & 7'h09);
  assign tick_send = state == SEND && bus.shift_enable;
  assign tick_gap  = state == GAP && bus.shift_enable;
  assign bus.ready   = state == IDLE;
  assign bus.cmd_out = out_q;
  assign bus.cmd_oe  = oe_q;
  assign bus.done    = done_q;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_d;
  always_comb
    state_d = (state == IDLE && bus.load)                    ? SEND :
              (tick_send && bit_cnt == 6'd0)                 ? GAP  :
              (tick_gap && gap_cnt == 8'd1)                  ? IDLE : state;
  always_comb begin
    out_d  = tick_send ? cur_bit : tick_gap ? 1'b1 : out_q;
    oe_d   = tick_send ? 1'b1 : tick_gap ? 1'b0 : oe_q;
    done_d = tick_gap && gap_cnt == 8'd1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_q  <= 1'b1;
      oe_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      done_q <= done_d;
    end
  always_ff @(posedge clk)
    if (rst) begin
      bit_cnt <= 6'd47;
      gap_cnt <= 8'd0;
      crc     <= 7'd0;
      idx     <= 6'd0;
      arg     <= 32'd0;
    end else if (state == IDLE) begin
      if (bus.load) begin
        idx     <= bus.cmd_index;
        arg     <= bus.cmd_arg;
        crc     <= 7'd0;
        bit_cnt <= 6'd47;
      end
    end else if (tick_send) begin
      if (bit_cnt >= 6'd8) crc <= crc_d;
      if (bit_cnt == 6'd0) gap_cnt <= 8'(NUM_IDLE_BITS);
      else                 bit_cnt <= bit_cnt - 6'd1;
    end else if (tick_gap) gap_cnt <= gap_cnt - 8'd1;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: randomized and directed check of sd_cmd_tx against a queue-based CMD stream model
module tb_sd_cmd_tx;
  localparam int NIB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sd_cmd_tx_if bus();
  sd_cmd_tx #(.NUM_IDLE_BITS(NIB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  logic [1:0]  q[$];
  logic        exp_out = 1'b1;
  logic        exp_oe = 1'b0;
  logic        exp_done = 1'b0;
  logic [47:0] cap = '0;
  int          ncap = 0;
  int          gap_run = 0;
  logic        in_gap = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    else n_pass++;
  endtask
  function automatic logic [47:0] frame_of(input logic [5:0] ix, input logic [31:0] ag);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, ix, ag};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = h[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {h, c, 1'b1};
  endfunction
  task automatic tick(input logic r, input logic ld, input logic se, input logic [5:0] ix, input logic [31:0] ag);
    logic [47:0] f;
    logic [1:0]  it;
    @(negedge clk);
    rst = r;
    bus.load = ld;
    bus.shift_enable = se;
    bus.cmd_index = ix;
    bus.cmd_arg = ag;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (r) begin
      q.delete();
      exp_out = 1'b1;
      exp_oe = 1'b0;
      ncap = 0;
      in_gap = 1'b0;
    end else if (q.size() == 0) begin
      if (ld) begin
        f = frame_of(ix, ag);
        for (int i = 47; i >= 0; i--) q.push_back({f[i], 1'b1});
        for (int i = 0; i < NIB; i++) q.push_back(2'b10);
      end
    end else if (se) begin
      it = q.pop_front();
      exp_out = it[1];
      exp_oe = it[0];
      exp_done = q.size() == 0;
    end
    chk("cyc", {bus.ready, bus.done, bus.cmd_oe, bus.cmd_out}, {q.size() == 0, exp_done, exp_oe, exp_out});
    if (!r && se && bus.cmd_oe) begin
      cap = {cap[46:0], bus.cmd_out};
      ncap++;
      if (ncap % 48 == 0) begin
        in_gap = 1'b1;
        gap_run = 0;
      end
    end else if (in_gap && se) gap_run++;
    if (in_gap && bus.done) begin
      chk("gap", gap_run, NIB);
      in_gap = 1'b0;
    end
  endtask
  task automatic send(input logic [5:0] ix, input logic [31:0] ag, input int per, input logic junk, input logic [47:0] want);
    int n;
    ncap = 0;
    tick(1'b0, 1'b1, 1'b1, ix, ag);
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      if (junk && n == 10) tick(1'b0, 1'b1, (n % per) == per - 1, 6'h3F, 32'hFFFF_FFFF);
      else tick(1'b0, 1'b0, (n % per) == per - 1, 6'($urandom), $urandom);
      n++;
    end
    chk("drain", q.size(), 0);
    chk("frame", cap, want);
    chk("oe_ticks", ncap, 48);
  endtask
  initial begin
    bus.load = 1'b1;
    bus.shift_enable = 1'b1;
    bus.cmd_index = 6'h2A;
    bus.cmd_arg = 32'h1234;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 6'h2A, 32'h1234);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 6'h2A, 32'h1234);
    send(6'd0, 32'h0, 1, 1'b0, 48'h4000_0000_0095);
    send(6'd8, 32'h1AA, 4, 1'b0, 48'h4800_0001_AA87);
    send(6'd5, 32'hCAFE_F00D, 2, 1'b1, frame_of(6'd5, 32'hCAFE_F00D));
    tick(1'b0, 1'b1, 1'b1, 6'd9, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, 6'd0, 32'd0);
    tick(1'b1, 1'b0, 1'b1, 6'd0, 32'd0);
    send(6'd17, 32'h0, 1, 1'b0, 48'h5100_0000_0055);
    ncap = 0;
    for (int i = 0; i < 2 * (48 + NIB) + 1; i++) tick(1'b0, 1'b1, 1'b1, 6'd12, 32'h0F0F_1234);
    chk("b2b_bits", ncap, 96);
    chk("b2b_frame", cap, frame_of(6'd12, 32'h0F0F_1234));
    for (int i = 0; i < NIB + 2; i++) tick(1'b0, 1'b0, 1'b1, 6'd0, 32'd0);
    for (int k = 0; k < 25; k++) begin
      logic [5:0]  ix;
      logic [31:0] ag;
      ix = 6'($urandom);
      ag = $urandom;
      send(ix, ag, int'($urandom_range(1, 3)), 1'($urandom), frame_of(ix, ag));
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) tick(1'b0, 1'b0, 1'($urandom), 6'($urandom), $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
SD-bus command-line transmitter that loads a 6-bit command index and a 32-bit argument and serializes them onto CMD. Each frame is 48 bits, MSB first: start bit, transmission bit, index, argument, CRC7 and end bit. It is the transmit counterpart of the serial-to-parallel receive path. Bit timing comes from an external shift_enable tick, so the block runs at any SD clock rate derived from clk.

Parameters:
NUM_IDLE_BITS, 8, number of high bit-periods driven after the end bit before the next command is accepted (Ncc); legal range 1..255

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
shift_enable  input  1  bit-period tick; one CMD bit advances per cycle it is high
load  input  1  command request; accepted only while ready=1
cmd_index  input  6  command index, captured on acceptance
cmd_arg  input  32  command argument, captured on acceptance
ready  output  1  high in IDLE; load is accepted this cycle
cmd_out  output  1  serial CMD data, registered, idle level 1
cmd_oe  output  1  CMD drive enable, registered
done  output  1  one-cycle pulse when the gap completes and IDLE is re-entered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, cmd_out=1, cmd_oe=0, done=0, bit counter=47, CRC=0.
- Reset takes priority over all other inputs, including mid-frame. The next edge after rst deasserts starts from IDLE with no residual frame or CRC state.
- Frame layout (bit 47 first): [47]=0, [46]=1, [45:40]=cmd_index, [39:8]=cmd_arg, [7:1]=CRC7, [0]=1.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8 MSB first. Sent MSB first.
- ready is combinational: ready = (state==IDLE).
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - cmd_out=1, cmd_oe=0.
  - On load=1, capture cmd_index and cmd_arg, clear CRC, set bit counter=47, go to SEND.
  - shift_enable on the acceptance cycle is ignored. No bit is emitted on the acceptance edge.
- SEND:
  - On each cycle with shift_enable=1: cmd_out <= frame[bit counter], cmd_oe <= 1, CRC updates while the counter is in 47..8.
  - If counter==0, load the gap counter with NUM_IDLE_BITS and go to GAP; otherwise decrement the counter.
  - Cycles with shift_enable=0 hold all outputs and state.
- GAP:
  - On each cycle with shift_enable=1: cmd_out <= 1, cmd_oe <= 0, decrement the gap counter.
  - When it reaches 0, go to IDLE and pulse done on the same edge, so done is high for the first IDLE cycle.
- Latency: the start bit appears on cmd_out on the first shift_enable edge strictly after acceptance.
- Drive window: cmd_oe is high for exactly 48 shift_enable ticks.
- load while ready=0 is ignored; captured values are unaffected.
- Input changes after acceptance have no effect on the frame in flight.
- Back-to-back: load asserted in the cycle done=1 (ready=1) is accepted.
- cmd_out and cmd_oe change only on shift_enable edges, on acceptance edges (no change), or on reset.

Test Plan:
1. Hold rst=1 for 3 cycles with load=1 and shift_enable=1 -> ready=1, cmd_out=1, cmd_oe=0, done=0 throughout; no frame starts after release until a fresh load.
2. Load cmd_index=0, cmd_arg=0x00000000, shift_enable=1 every cycle -> CMD sequence 0x400000000095 MSB first (CRC7=0x4A); cmd_oe high exactly 48 cycles; done pulses 8 ticks after the end bit.
3. Load cmd_index=8, cmd_arg=0x000001AA, shift_enable every 4th cycle -> sequence 0x48000001AA87 (CRC7=0x43); cmd_out is stable between ticks; no bit is emitted on the acceptance edge even with shift_enable=1 there.
4. Mid-frame, assert load with cmd_index=0x3F and cmd_arg=0xFFFFFFFF -> ignored; the in-flight frame completes unchanged and ready stays 0 until done.
5. Assert rst after 20 bits of a frame -> cmd_out=1, cmd_oe=0, ready=1 next cycle. A subsequent cmd_index=17, cmd_arg=0 load yields 0x510000000055 (CRC7=0x2A), proving the CRC is cleared.
6. Two commands back-to-back, the second load asserted in the done cycle -> second start bit on the next tick; the gap between end bit and start bit is exactly NUM_IDLE_BITS=8 high bits with cmd_oe=0.
